bp_fe_lce_link_tx: RTL and testbench

Transmit-side link adapter directly downstream of the front-end LCE. It accepts the LCE's request and response messages, buffers each in its own 2-entry queue, and arbitrates between them round-robin. The granted message is serialized onto a single narrow on-chip network link as fixed-width flits. A message is never interleaved with another message on the link.

---
 rtl/bp_fe_link_pkg.sv | 45 ++++
 rtl/bp_fe_lce_link_fifo.sv | 56 +++++
 rtl/bp_fe_lce_link_tx.sv | 170 +++++++++++++++++
 tb/tb_bp_fe_lce_link_tx.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_link_pkg.sv
// Shared types and helpers for the front-end LCE link transmitter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package bp_fe_link_pkg;

   // Message source carried on the link alongside each flit
   typedef enum logic {
      e_link_src_req  = 1'b0,
      e_link_src_resp = 1'b1
   } bp_fe_link_src_e;

   // Serializer state: waiting for work, or streaming one message
   typedef enum logic {
      e_link_idle = 1'b0,
      e_link_send = 1'b1
   } bp_fe_link_state_e;

   // Number of flits needed to carry a message of the given width
   function automatic int bp_fe_link_flits(input int width, input int flit_width);
      return (width + flit_width - 1) / flit_width;
   endfunction

   // Counter width able to index the longer of the two messages, never zero
   function automatic int bp_fe_link_cnt_width(input int a_flits, input int b_flits);
      int m;
      m = (a_flits > b_flits) ? a_flits : b_flits;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

   // Round-robin pick: a lone candidate wins, a tie goes to the source not served last
   function automatic bp_fe_link_src_e bp_fe_link_pick(input logic req_v,
                                                       input logic resp_v,
                                                       input bp_fe_link_src_e last);
      bp_fe_link_src_e pick;
      if (req_v && resp_v) begin
         pick = (last == e_link_src_req) ? e_link_src_resp : e_link_src_req;
      end else if (resp_v) begin
         pick = e_link_src_resp;
      end else begin
         pick = e_link_src_req;
      end
      return pick;
   endfunction

endpackage

// File: rtl/bp_fe_lce_link_fifo.sv
// Two-entry message queue in front of the link serializer.
// Latency: an entry written at edge t is visible at the head in cycle t+1; no bypass.
// Backpressure: ready_o depends only on occupancy and is low while full or in reset.
module bp_fe_lce_link_fifo
#(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic [width_p-1:0] data_o,
   output logic               v_o,
   output logic               full_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               wr_ptr_r;
   logic               rd_ptr_r;
   logic [1:0]         cnt_r;
   logic               enq;
   logic               deq;

   // full_o tells the arbiter a second entry sits behind the head
   assign full_o  = (cnt_r == 2'd2);
   assign v_o     = (cnt_r != 2'd0);
   assign ready_o = reset_n_i & ~full_o;
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; simultaneous enq/deq leaves occupancy unchanged
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         cnt_r    <= 2'd0;
      end else begin
         if (enq) wr_ptr_r <= ~wr_ptr_r;
         if (deq) rd_ptr_r <= ~rd_ptr_r;
         case ({enq, deq})
            2'b10:   cnt_r <= cnt_r + 2'd1;
            2'b01:   cnt_r <= cnt_r - 2'd1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Storage; contents only matter once the occupancy count covers them
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wr_ptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_fe_lce_link_tx.sv
// Queues LCE requests/responses and serializes them round-robin onto one flit link.
// Latency: message accepted at edge t puts its first flit on the link in cycle t+2.
// Backpressure: link_ready_i low holds the current flit; full queues drop x_ready_o.
module bp_fe_lce_link_tx
   import bp_fe_link_pkg::*;
#(
   parameter int req_width_p  = 96,
   parameter int resp_width_p = 608,
   parameter int flit_width_p = 64
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [req_width_p-1:0]  req_i,
   input  logic                    req_v_i,
   output logic                    req_ready_o,
   input  logic [resp_width_p-1:0] resp_i,
   input  logic                    resp_v_i,
   output logic                    resp_ready_o,
   output logic [flit_width_p-1:0] link_data_o,
   output logic                    link_v_o,
   output logic                    link_src_o,
   output logic                    link_last_o,
   input  logic                    link_ready_i,
   output logic                    busy_o
);

   localparam int req_flits_lp  = bp_fe_link_flits(req_width_p, flit_width_p);
   localparam int resp_flits_lp = bp_fe_link_flits(resp_width_p, flit_width_p);
   localparam int cnt_width_lp  = bp_fe_link_cnt_width(req_flits_lp, resp_flits_lp);
   localparam int req_pad_lp    = req_flits_lp * flit_width_p;
   localparam int resp_pad_lp   = resp_flits_lp * flit_width_p;

   localparam logic [cnt_width_lp-1:0] req_last_cnt_lp  = cnt_width_lp'(req_flits_lp - 1);
   localparam logic [cnt_width_lp-1:0] resp_last_cnt_lp = cnt_width_lp'(resp_flits_lp - 1);

   logic [req_width_p-1:0]  req_head;
   logic                    req_head_v;
   logic                    req_full;
   logic                    req_yumi;
   logic [resp_width_p-1:0] resp_head;
   logic                    resp_head_v;
   logic                    resp_full;
   logic                    resp_yumi;

   bp_fe_link_state_e       state_r, state_n;
   bp_fe_link_src_e         gnt_r, gnt_n;
   bp_fe_link_src_e         last_r, last_n;
   logic [cnt_width_lp-1:0] cnt_r, cnt_n;

   logic [req_pad_lp-1:0]   req_pad;
   logic [resp_pad_lp-1:0]  resp_pad;
   logic [flit_width_p-1:0] req_flit;
   logic [flit_width_p-1:0] resp_flit;
   logic                    flit_last;
   logic                    req_avail;
   logic                    resp_avail;

   bp_fe_lce_link_fifo #(.width_p(req_width_p)) req_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (req_i),
      .v_i       (req_v_i),
      .ready_o   (req_ready_o),
      .data_o    (req_head),
      .v_o       (req_head_v),
      .full_o    (req_full),
      .yumi_i    (req_yumi)
   );

   bp_fe_lce_link_fifo #(.width_p(resp_width_p)) resp_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (resp_i),
      .v_i       (resp_v_i),
      .ready_o   (resp_ready_o),
      .data_o    (resp_head),
      .v_o       (resp_head_v),
      .full_o    (resp_full),
      .yumi_i    (resp_yumi)
   );

   assign busy_o = (state_r == e_link_send) | req_head_v | resp_head_v;

   // Zero-pad each queue head to whole flits and select the flit at cnt_r
   always_comb begin
      req_pad                    = '0;
      req_pad[req_width_p-1:0]   = req_head;
      resp_pad                   = '0;
      resp_pad[resp_width_p-1:0] = resp_head;
      req_flit                   = '0;
      resp_flit                  = '0;
      if (int'(cnt_r) < req_flits_lp) begin
         req_flit = req_pad[int'(cnt_r) * flit_width_p +: flit_width_p];
      end
      if (int'(cnt_r) < resp_flits_lp) begin
         resp_flit = resp_pad[int'(cnt_r) * flit_width_p +: flit_width_p];
      end
   end

   // Arbitrate, step through flits, and re-arbitrate on the last-flit handshake
   always_comb begin
      state_n     = state_r;
      gnt_n       = gnt_r;
      last_n      = last_r;
      cnt_n       = cnt_r;
      req_yumi    = 1'b0;
      resp_yumi   = 1'b0;
      link_v_o    = 1'b0;
      link_data_o = '0;
      link_src_o  = 1'b0;
      link_last_o = 1'b0;
      flit_last   = (gnt_r == e_link_src_resp) ? (cnt_r == resp_last_cnt_lp)
                                               : (cnt_r == req_last_cnt_lp);
      req_avail   = req_head_v;
      resp_avail  = resp_head_v;

      unique case (state_r)
         e_link_idle: begin
            if (req_head_v || resp_head_v) begin
               state_n = e_link_send;
               cnt_n   = '0;
               gnt_n   = bp_fe_link_pick(req_head_v, resp_head_v, last_r);
            end
         end
         e_link_send: begin
            link_v_o    = 1'b1;
            link_src_o  = gnt_r;
            link_last_o = flit_last;
            link_data_o = (gnt_r == e_link_src_resp) ? resp_flit : req_flit;
            if (link_ready_i) begin
               if (!flit_last) begin
                  cnt_n = cnt_r + cnt_width_lp'(1);
               end else begin
                  req_yumi  = (gnt_r == e_link_src_req);
                  resp_yumi = (gnt_r == e_link_src_resp);
                  last_n    = gnt_r;
                  cnt_n     = '0;
                  // The granted queue only offers the entry behind the one leaving now
                  req_avail  = (gnt_r == e_link_src_req)  ? req_full  : req_head_v;
                  resp_avail = (gnt_r == e_link_src_resp) ? resp_full : resp_head_v;
                  if (req_avail || resp_avail) begin
                     gnt_n = bp_fe_link_pick(req_avail, resp_avail, gnt_r);
                  end else begin
                     state_n = e_link_idle;
                  end
               end
            end
         end
         default: begin
            state_n = e_link_idle;
         end
      endcase
   end

   // State register; last_r starts on the response so a first tie favours requests
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_link_idle;
         gnt_r   <= e_link_src_req;
         last_r  <= e_link_src_resp;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         gnt_r   <= gnt_n;
         last_r  <= last_n;
         cnt_r   <= cnt_n;
      end
   end

endmodule

// File: tb/tb_bp_fe_lce_link_tx.sv
// Self-checking bench for bp_fe_lce_link_tx: directed scenarios plus random traffic.
// A message-level reference model tracks accepted messages; a monitor checks every link cycle.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_bp_fe_lce_link_tx;
   localparam int RW = 96;
   localparam int SW = 608;
   localparam int FW = 64;
   localparam int RN = 2;
   localparam int SN = 10;
   localparam int RP = RN * FW;
   localparam int SP = SN * FW;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [RW-1:0] req_i;
   logic          req_v_i;
   logic          req_ready_o;
   logic [SW-1:0] resp_i;
   logic          resp_v_i;
   logic          resp_ready_o;
   logic [FW-1:0] link_data_o;
   logic          link_v_o;
   logic          link_src_o;
   logic          link_last_o;
   logic          link_ready_i;
   logic          busy_o;

   always #5 clk = ~clk;

   bp_fe_lce_link_tx dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n_i),
      .req_i        (req_i),
      .req_v_i      (req_v_i),
      .req_ready_o  (req_ready_o),
      .resp_i       (resp_i),
      .resp_v_i     (resp_v_i),
      .resp_ready_o (resp_ready_o),
      .link_data_o  (link_data_o),
      .link_v_o     (link_v_o),
      .link_src_o   (link_src_o),
      .link_last_o  (link_last_o),
      .link_ready_i (link_ready_i),
      .busy_o       (busy_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   function automatic logic [FW-1:0] req_flit(input logic [RW-1:0] m, input int i);
      logic [RP-1:0] p;
      p = RP'(m);
      return FW'(p >> (i * FW));
   endfunction

   function automatic logic [FW-1:0] resp_flit(input logic [SW-1:0] m, input int i);
      logic [SP-1:0] p;
      p = SP'(m);
      return FW'(p >> (i * FW));
   endfunction

   function automatic logic [RW-1:0] rand_req();
      logic [RW-1:0] r;
      for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [SW-1:0] rand_resp();
      logic [SW-1:0] r;
      for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: accepted messages per source with the cycle they were accepted in
   logic [RW-1:0] mq_req[$];
   int            ma_req[$];
   logic [SW-1:0] mq_resp[$];
   int            ma_resp[$];

   bit            in_msg;
   bit            cur_src;
   int            cur_cnt;
   bit            last_src;
   bit            prev_hold;
   logic [FW-1:0] prev_data;
   logic [1:0]    prev_ctl;

   // Monitor: checks every link cycle against the message-level model
   always @(negedge clk) begin
      bit el_req;
      bit el_resp;
      int nflits;
      if (!reset_n_i) begin
         chk("reset_outs", FW'({link_v_o, link_last_o, link_src_o, busy_o, req_ready_o, resp_ready_o}), '0);
         chk("reset_data", link_data_o, '0);
         mq_req.delete();  ma_req.delete();
         mq_resp.delete(); ma_resp.delete();
         in_msg = 0; last_src = 1; prev_hold = 0; cur_cnt = 0;
      end else begin
         chk("busy", busy_o, (mq_req.size() + mq_resp.size()) > 0);
         el_req  = mq_req.size()  > 0 && ma_req[0]  <= cyc - 2;
         el_resp = mq_resp.size() > 0 && ma_resp[0] <= cyc - 2;
         if (link_v_o) begin
            if (prev_hold) begin
               chk("hold_data", link_data_o, prev_data);
               chk("hold_ctl", FW'({link_src_o, link_last_o}), FW'(prev_ctl));
            end
            if (!in_msg) begin
               if (!(el_req || el_resp)) fail_msg("start_eligible", "flit with no eligible message");
               else chk("arb_src", link_src_o, (el_req && el_resp) ? !last_src : el_resp);
               in_msg  = 1;
               cur_src = link_src_o;
               cur_cnt = 0;
            end
            nflits = cur_src ? SN : RN;
            if (cur_src ? (mq_resp.size() == 0) : (mq_req.size() == 0)) begin
               fail_msg("model_empty", "flit for a source with no queued message");
            end else begin
               chk("flit_data", link_data_o,
                   cur_src ? resp_flit(mq_resp[0], cur_cnt) : req_flit(mq_req[0], cur_cnt));
            end
            chk("flit_src", link_src_o, cur_src);
            chk("flit_last", link_last_o, cur_cnt == nflits - 1);
            if (link_ready_i) begin
               prev_hold = 0;
               if (cur_cnt == nflits - 1) begin
                  if (cur_src && mq_resp.size() > 0) begin void'(mq_resp.pop_front()); void'(ma_resp.pop_front()); end
                  if (!cur_src && mq_req.size() > 0) begin void'(mq_req.pop_front()); void'(ma_req.pop_front()); end
                  last_src = cur_src;
                  in_msg   = 0;
               end else begin
                  cur_cnt++;
               end
            end else begin
               prev_hold = 1;
               prev_data = link_data_o;
               prev_ctl  = {link_src_o, link_last_o};
            end
         end else begin
            if (in_msg || prev_hold) fail_msg("v_drop", "link_v_o dropped mid-message");
            else if (el_req || el_resp) fail_msg("bubble", "idle link with an eligible message");
            else chk("idle_data", link_data_o, '0);
         end
         if (req_v_i && req_ready_o) begin mq_req.push_back(req_i); ma_req.push_back(cyc); end
         if (resp_v_i && resp_ready_o) begin mq_resp.push_back(resp_i); ma_resp.push_back(cyc); end
      end
   end

   task automatic wait_link_v(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!link_v_o && n < 30);
      if (!link_v_o) fail_msg(name, "timed out waiting for link_v_o");
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk); #1;
      req_v_i = 0; resp_v_i = 0; link_ready_i = 1;
      do begin
         @(negedge clk);
         n++;
      end while (busy_o && n < 300);
      if (busy_o) fail_msg("drain", "busy_o never cleared");
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      reset_n_i = 0;
      req_v_i = 0; resp_v_i = 0;
      repeat (2) @(negedge clk);
      #2 reset_n_i = 1;
      @(negedge clk);
      chk("ready_after_reset", FW'({req_ready_o, resp_ready_o}), 64'h3);
      @(posedge clk); #1;
   endtask

   task automatic enq_both();
      req_i = rand_req(); resp_i = rand_resp();
      req_v_i = 1; resp_v_i = 1;
      @(negedge clk);
      chk("both_acc", FW'({req_ready_o, resp_ready_o}), 64'h3);
      @(posedge clk); #1;
      req_v_i = 0; resp_v_i = 0;
   endtask

   // Drive random traffic (fair=0) or keep both queues saturated (fair=1)
   task automatic run_traffic(input int ncyc, input bit fair);
      bit rh, sh, have_prev, prev_src;
      have_prev = 0; prev_src = 0;
      req_v_i = 1; resp_v_i = 1; req_i = rand_req(); resp_i = rand_resp(); link_ready_i = 1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         rh = req_v_i & req_ready_o;
         sh = resp_v_i & resp_ready_o;
         if (fair && link_v_o && link_ready_i && link_last_o) begin
            if (have_prev) chk("fair_alt", link_src_o, !prev_src);
            prev_src  = link_src_o;
            have_prev = 1;
         end
         @(posedge clk); #1;
         if (fair) begin
            if (rh) req_i = rand_req();
            if (sh) resp_i = rand_resp();
         end else begin
            if (rh || !req_v_i) begin req_v_i = ($urandom_range(0, 1) == 1); req_i = rand_req(); end
            if (sh || !resp_v_i) begin resp_v_i = ($urandom_range(0, 2) == 0); resp_i = rand_resp(); end
            link_ready_i = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   initial begin
      logic [SW-1:0] bp_msg;
      logic [RW-1:0] r;
      bit            last_seen;
      bit            acc;
      int            n;

      reset_n_i = 1; req_v_i = 0; resp_v_i = 0; req_i = '0; resp_i = '0; link_ready_i = 0;
      #1 reset_n_i = 0;
      repeat (2) @(negedge clk);
      #2 reset_n_i = 1;
      @(negedge clk);
      chk("ready_after_reset", FW'({req_ready_o, resp_ready_o}), 64'h3);
      @(posedge clk); #1;

      // Single request: exact flits and timing
      req_i = 96'h0000_0001_2345_6789_ABCD_EF01; req_v_i = 1; link_ready_i = 1;
      @(negedge clk);
      chk("single_acc", req_ready_o, 1);
      @(posedge clk); #1 req_v_i = 0;
      @(negedge clk);
      chk("single_c1_v", link_v_o, 0);
      chk("single_c1_busy", busy_o, 1);
      @(negedge clk);
      chk("single_c2_data", link_data_o, 64'h2345_6789_ABCD_EF01);
      chk("single_c2_ctl", FW'({link_v_o, link_src_o, link_last_o}), 64'h4);
      @(negedge clk);
      chk("single_c3_data", link_data_o, 64'h0000_0000_0000_0001);
      chk("single_c3_ctl", FW'({link_v_o, link_src_o, link_last_o}), 64'h5);
      @(negedge clk);
      chk("single_c4_busy", busy_o, 0);
      @(posedge clk); #1;

      // Tie right after reset: request first, then 10 response flits back-to-back
      do_reset();
      link_ready_i = 1;
      enq_both();
      wait_link_v("tie_start");
      for (int i = 0; i < 12; i++) begin
         chk("tie_order", FW'({link_v_o, link_src_o}), FW'({1'b1, i >= 2}));
         @(negedge clk);
      end
      chk("tie_done", link_v_o, 0);
      @(posedge clk); #1;
      enq_both();
      wait_link_v("tie2_start");
      chk("tie2_first_src", link_src_o, 0);
      drain();

      // Backpressure on flit 3 of a response
      bp_msg = rand_resp(); resp_i = bp_msg; resp_v_i = 1; link_ready_i = 1;
      @(negedge clk);
      @(posedge clk); #1 resp_v_i = 0;
      wait_link_v("bp_start");
      repeat (2) @(negedge clk);
      @(posedge clk); #1 link_ready_i = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_data", link_data_o, resp_flit(bp_msg, 3));
         chk("bp_hold_v", link_v_o, 1);
      end
      @(posedge clk); #1 link_ready_i = 1;
      n = 3;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (link_v_o && link_ready_i) begin
            n++;
            if (link_last_o) break;
         end
      end
      chk("bp_len", FW'(n), 64'd10);
      drain();

      // Full request queue: third request waits for the first last-flit handshake
      link_ready_i = 0;
      req_v_i = 1; req_i = rand_req();
      @(negedge clk);
      @(posedge clk); #1 req_i = rand_req();
      @(negedge clk);
      chk("full_second_acc", req_ready_o, 1);
      @(posedge clk); #1 req_i = rand_req();
      repeat (4) begin
         @(negedge clk);
         chk("full_rdy", req_ready_o, 0);
      end
      @(posedge clk); #1 link_ready_i = 1;
      last_seen = 0; acc = 0;
      for (int k = 0; k < 10 && !acc; k++) begin
         @(negedge clk);
         chk("full_free", req_ready_o, last_seen);
         if (link_v_o && link_last_o && link_ready_i) last_seen = 1;
         acc = req_ready_o;
      end
      if (!acc) fail_msg("full_acc", "third request never accepted");
      drain();

      // Reset during flit 4 of a response
      resp_i = rand_resp(); resp_v_i = 1; link_ready_i = 1;
      @(negedge clk);
      @(posedge clk); #1 resp_v_i = 0;
      wait_link_v("rst_start");
      repeat (4) @(negedge clk);
      chk("rst_flit4_v", link_v_o, 1);
      #2 reset_n_i = 0;
      #1 chk("rst_immediate", link_v_o, 0);
      repeat (2) @(negedge clk);
      #2 reset_n_i = 1;
      @(posedge clk); #1;
      r = rand_req(); req_i = r; req_v_i = 1;
      @(negedge clk);
      @(posedge clk); #1 req_v_i = 0;
      wait_link_v("rst_next");
      chk("rst_next_src", link_src_o, 0);
      chk("rst_next_data", link_data_o, req_flit(r, 0));
      drain();

      // Fairness with both queues saturated, then random traffic
      run_traffic(60, 1'b1);
      drain();
      run_traffic(500, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
